// File: rtl/enc_pkg.sv
// Shared constants and search helpers for the request encoder family.
// Helpers take a MAX_N-wide vector; callers zero-extend narrower requests.
package enc_pkg;

  localparam int unsigned ENC_STRICT = 0;
  localparam int unsigned ENC_PRIO   = 1;
  localparam int unsigned ENC_RR     = 2;

  localparam int unsigned MAX_N  = 256;
  localparam int unsigned MAX_IW = 8;

  typedef struct packed {
    logic              found;
    logic [MAX_IW-1:0] idx;
  } lsb_t;

  function automatic logic is_onehot(input logic [MAX_N-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Descending scan so the last hit, i.e. the lowest set bit, is the one kept.
  function automatic lsb_t lsb_index(input logic [MAX_N-1:0] v);
    lsb_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.idx   = MAX_IW'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit at or above ptr, wrapping at N.
// The request is doubled so the wrapped search becomes a plain lowest-bit search.
module rr_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned PW = $clog2(2 * N);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [PW-1:0]  pos;

  assign dbl    = {req, req};
  assign masked = dbl & ({(2 * N){1'b1}} << ptr);

  always_comb begin
    pos = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        pos = PW'(i);
      end
    end
  end

  assign found = |req;
  assign idx   = (pos >= PW'(N)) ? IW'(pos - PW'(N)) : IW'(pos);

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with valid/ready on both sides, selectable
// strict one-hot, fixed-priority or round-robin selection, and an error counter.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 out_any,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned IW = $clog2(N);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $fatal(1, "prio_encoder_rr: N=%0d outside 2..%0d", N, MAX_N);
  end
  if (MODE > ENC_RR) begin : g_bad_mode
    $fatal(1, "prio_encoder_rr: illegal MODE=%0d", MODE);
  end

  logic          accept;
  logic [IW-1:0] enc_idx;
  logic          enc_any;
  logic [N-1:0]  enc_oh;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  if (MODE == ENC_STRICT) begin : g_strict
    logic [MAX_N-1:0] req_ext;
    lsb_t             lsb;
    assign req_ext = MAX_N'(req);
    assign lsb     = lsb_index(req_ext);
    assign enc_any = is_onehot(req_ext) && lsb.found;
    assign enc_idx = enc_any ? IW'(lsb.idx) : '0;
  end else if (MODE == ENC_PRIO) begin : g_prio
    logic [MAX_N-1:0] req_ext;
    lsb_t             lsb;
    assign req_ext = MAX_N'(req);
    assign lsb     = lsb_index(req_ext);
    assign enc_any = lsb.found;
    assign enc_idx = IW'(lsb.idx);
  end else begin : g_rr
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] rr_idx;
    logic          rr_found;

    rr_pick #(
      .N(N)
    ) u_rr_pick (
      .req  (req),
      .ptr  (ptr_q),
      .idx  (rr_idx),
      .found(rr_found)
    );

    assign enc_any = rr_found;
    assign enc_idx = rr_found ? rr_idx : '0;

    // Explicit compare keeps the wrap at N when N is not a power of two.
    always_comb begin
      ptr_d = ptr_q;
      if (accept && rr_found) begin
        ptr_d = (rr_idx == IW'(N - 1)) ? '0 : rr_idx + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end
  end

  assign enc_oh = enc_any ? (N'(1) << enc_idx) : '0;

  logic             valid_q, valid_d;
  logic             any_q, any_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N-1:0]     oh_q, oh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // In every mode an accepted code is invalid exactly when nothing was granted.
  always_comb begin
    valid_d = valid_q;
    any_d   = any_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      any_d   = enc_any;
      idx_d   = enc_idx;
      oh_d    = enc_oh;
      if (!enc_any && cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      any_q   <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      any_q   <= any_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_any    = any_q;
  assign out_idx    = idx_q;
  assign out_onehot = oh_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: five instances (strict, priority, RR N=8, RR N=5,
// strict with a 2-bit counter) driven in lockstep and checked against a reference model.
module tb_prio_encoder_rr;

  localparam int NI = 5;

  typedef struct {
    int unsigned inst;
    logic [7:0]  req;
    logic        rst_before;
    logic [7:0]  idx;
    logic        any;
    logic [7:0]  oh;
    logic [7:0]  cnt;
  } row_t;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] req8      = '0;
  logic [4:0] req5;

  assign req5 = req8[4:0];
  always #5 clk = ~clk;

  logic [2:0] idx0, idx1, idx2, idx3, idx4;
  logic [7:0] oh0, oh1, oh2, oh4;
  logic [4:0] oh3;
  logic       any0, any1, any2, any3, any4;
  logic       val0, val1, val2, val3, val4;
  logic       rdy0, rdy1, rdy2, rdy3, rdy4;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  logic [1:0] cnt4;

  prio_encoder_rr #(.N(8), .MODE(0), .CNT_W(8)) u_strict (
    .clk(clk), .rst(rst), .req(req8), .in_valid(in_valid), .in_ready(rdy0),
    .out_idx(idx0), .out_onehot(oh0), .out_any(any0), .out_valid(val0),
    .out_ready(out_ready), .err_cnt(cnt0)
  );
  prio_encoder_rr #(.N(8), .MODE(1), .CNT_W(8)) u_prio (
    .clk(clk), .rst(rst), .req(req8), .in_valid(in_valid), .in_ready(rdy1),
    .out_idx(idx1), .out_onehot(oh1), .out_any(any1), .out_valid(val1),
    .out_ready(out_ready), .err_cnt(cnt1)
  );
  prio_encoder_rr #(.N(8), .MODE(2), .CNT_W(8)) u_rr8 (
    .clk(clk), .rst(rst), .req(req8), .in_valid(in_valid), .in_ready(rdy2),
    .out_idx(idx2), .out_onehot(oh2), .out_any(any2), .out_valid(val2),
    .out_ready(out_ready), .err_cnt(cnt2)
  );
  prio_encoder_rr #(.N(5), .MODE(2), .CNT_W(8)) u_rr5 (
    .clk(clk), .rst(rst), .req(req5), .in_valid(in_valid), .in_ready(rdy3),
    .out_idx(idx3), .out_onehot(oh3), .out_any(any3), .out_valid(val3),
    .out_ready(out_ready), .err_cnt(cnt3)
  );
  prio_encoder_rr #(.N(8), .MODE(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .req(req8), .in_valid(in_valid), .in_ready(rdy4),
    .out_idx(idx4), .out_onehot(oh4), .out_any(any4), .out_valid(val4),
    .out_ready(out_ready), .err_cnt(cnt4)
  );

  logic [7:0] o_idx[NI];
  logic [7:0] o_oh[NI];
  logic [7:0] o_cnt[NI];
  logic       o_any[NI];
  logic       o_val[NI];
  logic       o_rdy[NI];

  assign o_idx[0] = {5'd0, idx0};
  assign o_idx[1] = {5'd0, idx1};
  assign o_idx[2] = {5'd0, idx2};
  assign o_idx[3] = {5'd0, idx3};
  assign o_idx[4] = {5'd0, idx4};
  assign o_oh[0]  = oh0;
  assign o_oh[1]  = oh1;
  assign o_oh[2]  = oh2;
  assign o_oh[3]  = {3'd0, oh3};
  assign o_oh[4]  = oh4;
  assign o_cnt[0] = cnt0;
  assign o_cnt[1] = cnt1;
  assign o_cnt[2] = cnt2;
  assign o_cnt[3] = cnt3;
  assign o_cnt[4] = {6'd0, cnt4};
  assign o_any[0] = any0;
  assign o_any[1] = any1;
  assign o_any[2] = any2;
  assign o_any[3] = any3;
  assign o_any[4] = any4;
  assign o_val[0] = val0;
  assign o_val[1] = val1;
  assign o_val[2] = val2;
  assign o_val[3] = val3;
  assign o_val[4] = val4;
  assign o_rdy[0] = rdy0;
  assign o_rdy[1] = rdy1;
  assign o_rdy[2] = rdy2;
  assign o_rdy[3] = rdy3;
  assign o_rdy[4] = rdy4;

  // Reference model state, one slot per instance
  int         m_mode[NI] = '{0, 1, 2, 2, 0};
  int         m_n[NI]    = '{8, 8, 8, 5, 8};
  int         m_max[NI]  = '{255, 255, 255, 255, 3};
  logic [7:0] m_mask[NI] = '{8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'hFF};
  bit         mv[NI];
  bit         many[NI];
  int         midx[NI];
  logic [7:0] moh[NI];
  int         mcnt[NI];
  int         mptr[NI];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void ref_enc(input int mode, input int n, input logic [7:0] r,
                                  input int p, output int idx, output bit any, output bit err);
    idx = 0;
    any = 1'b0;
    if (mode == 0) begin
      err = ($countones(r) != 1);
      if (!err) begin
        any = 1'b1;
        for (int k = 0; k < n; k++) if (r[k]) idx = k;
      end
    end else if (mode == 1) begin
      err = (r == 8'd0);
      for (int k = n - 1; k >= 0; k--) if (r[k]) begin idx = k; any = 1'b1; end
    end else begin
      err = (r == 8'd0);
      for (int k = n - 1; k >= 0; k--) begin
        if (r[(p + k) % n]) begin idx = (p + k) % n; any = 1'b1; end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      mv[i] = 1'b0; many[i] = 1'b0; midx[i] = 0; moh[i] = '0; mcnt[i] = 0; mptr[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < NI; i++) begin
      logic [7:0] r;
      int         idx;
      bit         any;
      bit         err;
      r = req8 & m_mask[i];
      if (in_valid && (!mv[i] || out_ready)) begin
        ref_enc(m_mode[i], m_n[i], r, mptr[i], idx, any, err);
        mv[i]   = 1'b1;
        many[i] = any;
        midx[i] = idx;
        moh[i]  = any ? 8'(1 << idx) : 8'd0;
        if (err && mcnt[i] < m_max[i]) mcnt[i]++;
        if (m_mode[i] == 2 && any) mptr[i] = (idx + 1) % m_n[i];
      end else if (out_ready) begin
        mv[i] = 1'b0;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (o_val[i] !== mv[i] || o_any[i] !== many[i] || o_idx[i] !== 8'(midx[i]) ||
          o_oh[i] !== moh[i] || o_cnt[i] !== 8'(mcnt[i])) begin
        n_fail++;
        $display("FAIL %s inst%0d: got v=%b any=%b idx=%0d oh=%h cnt=%0d, want v=%b any=%b idx=%0d oh=%h cnt=%0d",
                 tag, i, o_val[i], o_any[i], o_idx[i], o_oh[i], o_cnt[i],
                 mv[i], many[i], midx[i], moh[i], mcnt[i]);
      end
    end
  endtask

  task automatic check_ready(input string tag);
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (o_rdy[i] !== (!mv[i] || out_ready)) begin
        n_fail++;
        $display("FAIL %s_in_ready inst%0d: got %b want %b", tag, i, o_rdy[i], (!mv[i] || out_ready));
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input string tag);
    #1;
    check_ready(tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  // Assert reset between edges so its effect is checked before any clock
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("reset_async");
    check_ready("reset_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all("reset");
  endtask

  initial begin
    row_t        tbl[$];
    int unsigned t;

    // inst, req, rst_before, idx, any, onehot, err_cnt
    tbl.push_back('{0, 8'h04, 1'b1, 8'd2, 1'b1, 8'h04, 8'd0});
    tbl.push_back('{0, 8'h06, 1'b0, 8'd0, 1'b0, 8'h00, 8'd1});
    tbl.push_back('{0, 8'h00, 1'b0, 8'd0, 1'b0, 8'h00, 8'd2});
    tbl.push_back('{4, 8'h00, 1'b1, 8'd0, 1'b0, 8'h00, 8'd1});
    tbl.push_back('{4, 8'h00, 1'b0, 8'd0, 1'b0, 8'h00, 8'd2});
    tbl.push_back('{4, 8'h00, 1'b0, 8'd0, 1'b0, 8'h00, 8'd3});
    tbl.push_back('{4, 8'h00, 1'b0, 8'd0, 1'b0, 8'h00, 8'd3});
    tbl.push_back('{4, 8'h00, 1'b0, 8'd0, 1'b0, 8'h00, 8'd3});
    tbl.push_back('{1, 8'hA8, 1'b1, 8'd3, 1'b1, 8'h08, 8'd0});
    tbl.push_back('{1, 8'h80, 1'b0, 8'd7, 1'b1, 8'h80, 8'd0});
    tbl.push_back('{2, 8'h91, 1'b1, 8'd0, 1'b1, 8'h01, 8'd0});
    tbl.push_back('{2, 8'h91, 1'b0, 8'd4, 1'b1, 8'h10, 8'd0});
    tbl.push_back('{2, 8'h91, 1'b0, 8'd7, 1'b1, 8'h80, 8'd0});
    tbl.push_back('{2, 8'h91, 1'b0, 8'd0, 1'b1, 8'h01, 8'd0});
    tbl.push_back('{3, 8'h11, 1'b1, 8'd0, 1'b1, 8'h01, 8'd0});
    tbl.push_back('{3, 8'h11, 1'b0, 8'd4, 1'b1, 8'h10, 8'd0});
    tbl.push_back('{3, 8'h11, 1'b0, 8'd0, 1'b1, 8'h01, 8'd0});

    do_reset();

    foreach (tbl[k]) begin
      if (tbl[k].rst_before) do_reset();
      req8      = tbl[k].req;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cycle($sformatf("row%0d", k));
      t = tbl[k].inst;
      n_tests++;
      if ({o_val[t], o_any[t], o_idx[t], o_oh[t], o_cnt[t]} !==
          {1'b1, tbl[k].any, tbl[k].idx, tbl[k].oh, tbl[k].cnt}) begin
        n_fail++;
        $display("FAIL row%0d inst%0d: got v=%b any=%b idx=%0d oh=%h cnt=%0d, want v=1 any=%b idx=%0d oh=%h cnt=%0d",
                 k, t, o_val[t], o_any[t], o_idx[t], o_oh[t], o_cnt[t],
                 tbl[k].any, tbl[k].idx, tbl[k].oh, tbl[k].cnt);
      end
    end

    // Backpressure: hold for 3 cycles, then consume and accept together
    do_reset();
    req8 = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
    cycle("bp_fill");
    chk("bp_fill_idx", 32'(idx1), 32'd4);
    out_ready = 1'b0;
    req8      = 8'h02;
    for (int c = 0; c < 3; c++) begin
      cycle("bp_hold");
      chk("bp_hold_in_ready", 32'(rdy1), 32'd0);
      chk("bp_hold_idx", 32'(idx1), 32'd4);
      chk("bp_hold_valid", 32'(val1), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(rdy1), 32'd1);
    cycle("bp_release");
    chk("bp_release_valid", 32'(val1), 32'd1);
    chk("bp_release_idx", 32'(idx1), 32'd1);
    in_valid = 1'b0;
    cycle("bp_drain");
    chk("bp_drain_valid", 32'(val1), 32'd0);
    chk("bp_drain_idx_hold", 32'(idx1), 32'd1);

    // Randomised traffic with occasional mid-stream resets
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       req8 = 8'h00;
        1:       req8 = 8'(1 << $urandom_range(0, 7));
        default: req8 = 8'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
